// File: rtl/write_back.sv
// write_back: final pipeline stage that commits a process-stage result.
// Captures one result per handshake, then performs up to two memory writes
// (byte to dest_addr, or the A/B pair), an optional PSW update, and a
// one-cycle completion pulse. A write that is not acknowledged within
// MEM_ACK_TIMEOUT stall cycles is abandoned and flagged on wb_err.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   wb_valid/wb_ready  result handshake (ready only in IDLE)
//   wb_mode, psw_wr    write kind and PSW-update request
//   ans, ans_hi        low/high result bytes
//   psw_in, dest_addr  new PSW value, direct destination address
//   mem_we/addr/wdata  IRAM/SFR write port, mem_ack accepts a write
//   psw_we, psw_out    PSW write port
//   wb_done, wb_err    completion and error pulses
module write_back #(
  parameter int unsigned MEM_ACK_TIMEOUT = 15  // must be >= 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wb_valid,
  output logic       wb_ready,
  input  logic [1:0] wb_mode,
  input  logic       psw_wr,
  input  logic [7:0] ans,
  input  logic [7:0] ans_hi,
  input  logic [7:0] psw_in,
  input  logic [7:0] dest_addr,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic       mem_ack,
  output logic       psw_we,
  output logic [7:0] psw_out,
  output logic       wb_done,
  output logic       wb_err
);

  localparam int unsigned CNT_W = (MEM_ACK_TIMEOUT < 2) ? 1 : $clog2(MEM_ACK_TIMEOUT);
  localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'(MEM_ACK_TIMEOUT - 1);

  localparam logic [1:0] MODE_PSW  = 2'b00;
  localparam logic [1:0] MODE_BYTE = 2'b01;
  localparam logic [1:0] MODE_PAIR = 2'b10;
  localparam logic [7:0] ADDR_ACC  = 8'hE0;
  localparam logic [7:0] ADDR_B    = 8'hF0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR0  = 3'd1,
    S_WR1  = 3'd2,
    S_PSW  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           r_state;
  logic [1:0]       r_mode;
  logic             r_psw_wr;
  logic [7:0]       r_ans;
  logic [7:0]       r_ans_hi;
  logic [7:0]       r_psw_in;
  logic [7:0]       r_dest;
  logic [CNT_W-1:0] r_stall;

  logic       r_wb_ready;
  logic       r_mem_we;
  logic [7:0] r_mem_addr;
  logic [7:0] r_mem_wdata;
  logic       r_psw_we;
  logic [7:0] r_psw_out;
  logic       r_wb_done;
  logic       r_wb_err;

  state_t           w_state_nx;
  logic [1:0]       w_mode_nx;
  logic             w_psw_wr_nx;
  logic [7:0]       w_ans_nx;
  logic [7:0]       w_ans_hi_nx;
  logic [7:0]       w_psw_in_nx;
  logic [7:0]       w_dest_nx;
  logic [CNT_W-1:0] w_stall_nx;
  logic             w_err_nx;
  logic             w_par_sel;

  logic       w_wb_ready_nx;
  logic       w_mem_we_nx;
  logic [7:0] w_mem_addr_nx;
  logic [7:0] w_mem_wdata_nx;
  logic       w_psw_we_nx;
  logic [7:0] w_psw_out_nx;
  logic       w_wb_done_nx;
  logic       w_wb_err_nx;

  // Next state, capture and stall counting.
  always_comb begin
    w_state_nx  = r_state;
    w_mode_nx   = r_mode;
    w_psw_wr_nx = r_psw_wr;
    w_ans_nx    = r_ans;
    w_ans_hi_nx = r_ans_hi;
    w_psw_in_nx = r_psw_in;
    w_dest_nx   = r_dest;
    w_stall_nx  = r_stall;
    w_err_nx    = 1'b0;

    case (r_state)
      S_IDLE: begin
        // r_wb_ready is low for the first cycle out of reset, so nothing is taken then.
        if (r_wb_ready && wb_valid) begin
          w_mode_nx   = wb_mode;
          w_psw_wr_nx = psw_wr;
          w_ans_nx    = ans;
          w_ans_hi_nx = ans_hi;
          w_psw_in_nx = psw_in;
          w_dest_nx   = dest_addr;
          case (wb_mode)
            MODE_BYTE, MODE_PAIR: w_state_nx = S_WR0;
            MODE_PSW:             w_state_nx = psw_wr ? S_PSW : S_DONE;
            default: begin
              w_state_nx = S_DONE;
              w_err_nx   = 1'b1;
            end
          endcase
        end
      end
      S_WR0, S_WR1: begin
        if (mem_ack) begin
          if (r_state == S_WR0 && r_mode == MODE_PAIR) w_state_nx = S_WR1;
          else                                         w_state_nx = r_psw_wr ? S_PSW : S_DONE;
        end else if (r_stall == STALL_LAST) begin
          // Timeout: drop the remaining writes and the PSW update.
          w_state_nx = S_DONE;
          w_err_nx   = 1'b1;
        end else begin
          w_stall_nx = r_stall + CNT_W'(1);
        end
      end
      S_PSW:   w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    if (w_state_nx != r_state) w_stall_nx = '0;
  end

  // Next registered outputs, decoded from the state being entered.
  always_comb begin
    w_wb_ready_nx  = 1'b0;
    w_mem_we_nx    = 1'b0;
    w_mem_addr_nx  = 8'h00;
    w_mem_wdata_nx = 8'h00;
    w_psw_we_nx    = 1'b0;
    w_psw_out_nx   = 8'h00;
    w_wb_done_nx   = 1'b0;
    w_wb_err_nx    = 1'b0;
    // Parity tracks the accumulator only when this result lands in A.
    w_par_sel = (w_mode_nx == MODE_PAIR) ||
                ((w_mode_nx == MODE_BYTE) && (w_dest_nx == ADDR_ACC));

    case (w_state_nx)
      S_IDLE: w_wb_ready_nx = 1'b1;
      S_WR0: begin
        w_mem_we_nx    = 1'b1;
        w_mem_addr_nx  = (w_mode_nx == MODE_PAIR) ? ADDR_ACC : w_dest_nx;
        w_mem_wdata_nx = w_ans_nx;
      end
      S_WR1: begin
        w_mem_we_nx    = 1'b1;
        w_mem_addr_nx  = ADDR_B;
        w_mem_wdata_nx = w_ans_hi_nx;
      end
      S_PSW: begin
        w_psw_we_nx  = 1'b1;
        w_psw_out_nx = {w_psw_in_nx[7:1], w_par_sel ? ^w_ans_nx : w_psw_in_nx[0]};
      end
      S_DONE: begin
        w_wb_done_nx = 1'b1;
        w_wb_err_nx  = w_err_nx;
      end
      default: w_wb_ready_nx = 1'b0;
    endcase
  end

  // State, captured operands and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_mode      <= 2'b00;
      r_psw_wr    <= 1'b0;
      r_ans       <= 8'h00;
      r_ans_hi    <= 8'h00;
      r_psw_in    <= 8'h00;
      r_dest      <= 8'h00;
      r_stall     <= '0;
      r_wb_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 8'h00;
      r_mem_wdata <= 8'h00;
      r_psw_we    <= 1'b0;
      r_psw_out   <= 8'h00;
      r_wb_done   <= 1'b0;
      r_wb_err    <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_mode      <= w_mode_nx;
      r_psw_wr    <= w_psw_wr_nx;
      r_ans       <= w_ans_nx;
      r_ans_hi    <= w_ans_hi_nx;
      r_psw_in    <= w_psw_in_nx;
      r_dest      <= w_dest_nx;
      r_stall     <= w_stall_nx;
      r_wb_ready  <= w_wb_ready_nx;
      r_mem_we    <= w_mem_we_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_psw_we    <= w_psw_we_nx;
      r_psw_out   <= w_psw_out_nx;
      r_wb_done   <= w_wb_done_nx;
      r_wb_err    <= w_wb_err_nx;
    end
  end

  assign wb_ready  = r_wb_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign psw_we    = r_psw_we;
  assign psw_out   = r_psw_out;
  assign wb_done   = r_wb_done;
  assign wb_err    = r_wb_err;

endmodule

// File: tb/tb_write_back.sv
// tb_write_back: self-checking bench for write_back. Known vectors from a
// table, hand-written reset sequences, and random transactions checked cycle
// by cycle against a transaction-level timeline model.
module tb_write_back;

  localparam int unsigned TO = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wb_valid;
  logic       wb_ready;
  logic [1:0] wb_mode;
  logic       psw_wr;
  logic [7:0] ans, ans_hi, psw_in, dest_addr;
  logic       mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic       mem_ack;
  logic       psw_we;
  logic [7:0] psw_out;
  logic       wb_done, wb_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  write_back #(.MEM_ACK_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_mode(wb_mode), .psw_wr(psw_wr), .ans(ans), .ans_hi(ans_hi),
    .psw_in(psw_in), .dest_addr(dest_addr), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .psw_we(psw_we), .psw_out(psw_out), .wb_done(wb_done), .wb_err(wb_err)
  );

  // Output vector: {ready, mem_we, addr, wdata, psw_we, psw_out, done, err}.
  function automatic logic [28:0] pk(logic rdy, logic we, logic [7:0] a, logic [7:0] d,
                                     logic pwe, logic [7:0] po, logic dn, logic er);
    return {rdy, we, a, d, pwe, po, dn, er};
  endfunction

  function automatic logic [28:0] raw_out();
    return pk(wb_ready, mem_we, mem_addr, mem_wdata, psw_we, psw_out, wb_done, wb_err);
  endfunction

  // Data buses only matter while their strobe is high.
  function automatic logic [28:0] obs_out();
    return pk(wb_ready, mem_we, mem_we ? mem_addr : 8'h00, mem_we ? mem_wdata : 8'h00,
              psw_we, psw_we ? psw_out : 8'h00, wb_done, wb_err);
  endfunction

  task automatic check(input string name, input logic [28:0] act, input logic [28:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One transaction. ack[c] is the mem_ack level presented during cycle c
  // after acceptance (cycle 0). Expected outputs per cycle come from a
  // timeline built from the write list and the ack pattern.
  task automatic run_txn(input logic [1:0] mode, input logic pw, input logic [7:0] a,
                         input logic [7:0] hi, input logic [7:0] pin, input logic [7:0] dst,
                         input logic [63:0] ack, input string tag,
                         output int done_cyc, output int n_wr, output int n_psw,
                         output logic [7:0] psw_val, output logic err_seen);
    logic [28:0] exp [64];
    logic [7:0]  wa [2];
    logic [7:0]  wd [2];
    int nw, c, stalls, last;
    logic bad, p0;

    for (int i = 0; i < 64; i++) exp[i] = '0;
    nw = 0;
    if (mode == 2'b01) begin
      wa[0] = dst; wd[0] = a; nw = 1;
    end else if (mode == 2'b10) begin
      wa[0] = 8'hE0; wd[0] = a; wa[1] = 8'hF0; wd[1] = hi; nw = 2;
    end
    bad = (mode == 2'b11);
    c = 1;
    for (int w = 0; w < nw && !bad; w++) begin
      stalls = 0;
      while (1) begin
        exp[c] = pk(1'b0, 1'b1, wa[w], wd[w], 1'b0, 8'h00, 1'b0, 1'b0);
        if (ack[c]) begin
          c++;
          break;
        end
        stalls++;
        c++;
        if (stalls == int'(TO)) begin
          bad = 1'b1;
          break;
        end
      end
    end
    if (!bad && pw) begin
      p0 = (mode == 2'b10 || (mode == 2'b01 && dst == 8'hE0)) ? ^a : pin[0];
      exp[c] = pk(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, {pin[7:1], p0}, 1'b0, 1'b0);
      c++;
    end
    exp[c] = pk(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1, bad);
    last = c;

    check({tag, "_ready"}, 29'(wb_ready), 29'(1));
    wb_valid = 1'b1; wb_mode = mode; psw_wr = pw; ans = a; ans_hi = hi;
    psw_in = pin; dest_addr = dst; mem_ack = 1'($urandom);
    step();

    done_cyc = -1; n_wr = 0; n_psw = 0; psw_val = 8'h00; err_seen = 1'b0;
    for (int k = 1; k <= last; k++) begin
      check({tag, "_cyc"}, obs_out(), exp[k]);
      if (mem_we && ack[k]) n_wr++;
      if (psw_we) begin
        n_psw++;
        psw_val = psw_out;
      end
      if (wb_done && done_cyc < 0) done_cyc = k;
      if (wb_err) err_seen = 1'b1;
      // Busy: inputs must be ignored, so scramble them.
      mem_ack = ack[k];
      wb_valid = 1'($urandom); wb_mode = 2'($urandom); psw_wr = 1'($urandom);
      ans = 8'($urandom); ans_hi = 8'($urandom); psw_in = 8'($urandom);
      dest_addr = 8'($urandom);
      step();
    end
    wb_valid = 1'b0;
    mem_ack = 1'b0;
  endtask

  typedef struct {
    logic [1:0] mode;
    logic       pw;
    logic [7:0] a, hi, pin, dst;
    int         s0, s1;
    int         e_done, e_wr, e_psw;
    logic [7:0] e_pval;
    logic       e_err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int dc, nwr, npsw;
    logic [7:0] pv;
    logic er;
    logic [63:0] ak;

    //          mode  pw    a      hi     pin    dst    s0  s1  done wr psw pval   err
    tbl[0]  = '{2'b01, 1'b0, 8'h5A, 8'h00, 8'h00, 8'h30, 0,  0,  2,   1, 0, 8'h00, 1'b0};
    tbl[1]  = '{2'b10, 1'b1, 8'h10, 8'h27, 8'h84, 8'h00, 0,  0,  4,   2, 1, 8'h85, 1'b0};
    tbl[2]  = '{2'b01, 1'b0, 8'h3C, 8'h00, 8'h00, 8'h45, 3,  0,  5,   1, 0, 8'h00, 1'b0};
    tbl[3]  = '{2'b10, 1'b1, 8'h11, 8'h22, 8'h00, 8'h00, 15, 0,  16,  0, 0, 8'h00, 1'b1};
    tbl[4]  = '{2'b00, 1'b1, 8'h00, 8'h00, 8'hC1, 8'h00, 0,  0,  2,   0, 1, 8'hC1, 1'b0};
    tbl[5]  = '{2'b11, 1'b1, 8'h77, 8'h00, 8'hFF, 8'h00, 0,  0,  1,   0, 0, 8'h00, 1'b1};
    tbl[6]  = '{2'b01, 1'b1, 8'h03, 8'h00, 8'h01, 8'hE0, 0,  0,  3,   1, 1, 8'h00, 1'b0};
    tbl[7]  = '{2'b01, 1'b1, 8'h01, 8'h00, 8'h40, 8'h81, 0,  0,  3,   1, 1, 8'h40, 1'b0};
    tbl[8]  = '{2'b00, 1'b0, 8'hAA, 8'h00, 8'h12, 8'h00, 0,  0,  1,   0, 0, 8'h00, 1'b0};
    tbl[9]  = '{2'b10, 1'b0, 8'h01, 8'h02, 8'h00, 8'h00, 14, 0,  17,  2, 0, 8'h00, 1'b0};
    tbl[10] = '{2'b10, 1'b1, 8'h05, 8'h06, 8'h00, 8'h00, 0,  15, 17,  1, 0, 8'h00, 1'b1};

    rst_n = 1'b0; wb_valid = 1'b0; wb_mode = 2'b00; psw_wr = 1'b0; ans = 8'h00;
    ans_hi = 8'h00; psw_in = 8'h00; dest_addr = 8'h00; mem_ack = 1'b1;
    step();
    step();
    check("reset_outputs", raw_out(), '0);
    rst_n = 1'b1;
    mem_ack = 1'b0;
    step();
    check("ready_after_reset", raw_out(), pk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));

    for (int v = 0; v < 11; v++) begin
      ak = '1;
      for (int i = 1; i <= tbl[v].s0; i++) ak[i] = 1'b0;
      ak[tbl[v].s0 + 1] = 1'b1;
      for (int i = tbl[v].s0 + 2; i <= tbl[v].s0 + 1 + tbl[v].s1; i++) ak[i] = 1'b0;
      run_txn(tbl[v].mode, tbl[v].pw, tbl[v].a, tbl[v].hi, tbl[v].pin, tbl[v].dst, ak,
              $sformatf("vec%0d", v), dc, nwr, npsw, pv, er);
      check_i($sformatf("vec%0d_done_cycle", v), dc, tbl[v].e_done);
      check_i($sformatf("vec%0d_writes", v), nwr, tbl[v].e_wr);
      check_i($sformatf("vec%0d_psw_count", v), npsw, tbl[v].e_psw);
      check_i($sformatf("vec%0d_err", v), int'(er), int'(tbl[v].e_err));
      if (tbl[v].e_psw != 0) check_i($sformatf("vec%0d_psw_val", v), int'(pv), int'(tbl[v].e_pval));
    end

    // Reset while the second write of a pair is pending.
    check("midrst_ready", 29'(wb_ready), 29'(1));
    wb_valid = 1'b1; wb_mode = 2'b10; psw_wr = 1'b1; ans = 8'h9C; ans_hi = 8'h3D;
    psw_in = 8'h00; mem_ack = 1'b0;
    step();
    wb_valid = 1'b0;
    check("midrst_wr0", raw_out(), pk(1'b0, 1'b1, 8'hE0, 8'h9C, 1'b0, 8'h00, 1'b0, 1'b0));
    mem_ack = 1'b1;
    step();
    check("midrst_wr1", raw_out(), pk(1'b0, 1'b1, 8'hF0, 8'h3D, 1'b0, 8'h00, 1'b0, 1'b0));
    rst_n = 1'b0;
    step();
    check("midrst_in_reset", raw_out(), '0);
    rst_n = 1'b1;
    step();
    check("midrst_release", raw_out(), pk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      step();
      check("midrst_quiet", raw_out(), pk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
    end
    mem_ack = 1'b0;

    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 7) == 0) ak = '0;
      else ak = {$urandom, $urandom};
      run_txn(2'($urandom_range(0, 3)), 1'($urandom),
              8'($urandom), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 3) == 0) ? 8'hE0 : 8'($urandom),
              ak, "rnd", dc, nwr, npsw, pv, er);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/write_back.md
WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 The block SHALL have parameter MEM_ACK_TIMEOUT, default 15, meaning the number of stall cycles waited for mem_ack before a write is abandoned.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, synchronous active-low reset, sampled on the clk rising edge.
REQ-004 The block SHALL have port wb_valid, input, 1, result from the process stage is present.
REQ-005 The block SHALL have port wb_ready, output, 1, the block accepts a result this cycle.
REQ-006 The block SHALL have port wb_mode, input, 2, the write kind: 00 = PSW only, 01 = byte to dest_addr, 10 = pair (ans to A, ans_hi to B).
REQ-007 The block SHALL have port psw_wr, input, 1, PSW update requested.
REQ-008 The block SHALL have port ans, input, 8, low/primary result byte.
REQ-009 The block SHALL have port ans_hi, input, 8, high result byte (MUL/DIV).
REQ-010 The block SHALL have port psw_in, input, 8, PSW value produced by the process stage.
REQ-011 The block SHALL have port dest_addr, input, 8, direct destination address for mode 01.
REQ-012 The block SHALL have port mem_we, output, 1, write strobe to IRAM/SFR.
REQ-013 The block SHALL have port mem_addr, output, 8, write address.
REQ-014 The block SHALL have port mem_wdata, output, 8, write data.
REQ-015 The block SHALL have port mem_ack, input, 1, the write is accepted in the cycle it is high while mem_we is high.
REQ-016 The block SHALL have port psw_we, output, 1, PSW write strobe.
REQ-017 The block SHALL have port psw_out, output, 8, PSW value to write.
REQ-018 The block SHALL have port wb_done, output, 1, one-cycle completion pulse.
REQ-019 The block SHALL have port wb_err, output, 1, one-cycle pulse when a write times out.

Function
REQ-020 The FSM SHALL have states IDLE, WR0, WR1, PSW and DONE; wb_ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, when wb_valid=1, the block SHALL capture wb_mode, psw_wr, ans, ans_hi, psw_in and dest_addr into internal registers; inputs are ignored after the capture.
REQ-022 The next state after capture SHALL be: mode 01 or 10 -> WR0; mode 00 with psw_wr=1 -> PSW; mode 00 with psw_wr=0 -> DONE; mode 11 -> DONE with wb_err=1.
REQ-023 In WR0, mem_we SHALL be 1 with mem_addr = captured dest_addr (mode 01) or 0xE0 (mode 10), and mem_wdata = captured ans.
REQ-024 In WR1, mem_we SHALL be 1 with mem_addr = 0xF0 and mem_wdata = captured ans_hi.
REQ-025 mem_addr and mem_wdata SHALL be held stable while mem_we=1 and mem_ack=0.
REQ-026 On mem_ack in WR0, the block SHALL go to WR1 for mode 10; otherwise it SHALL go to PSW if psw_wr=1, else DONE.
REQ-027 On mem_ack in WR1, the block SHALL go to PSW if psw_wr=1, else DONE.
REQ-028 A stall counter SHALL count cycles in WR0/WR1 with mem_ack=0 and clear on each state entry.
REQ-029 When the stall counter reaches MEM_ACK_TIMEOUT, the block SHALL pulse wb_err for 1 cycle, drop mem_we, skip the remaining writes and PSW, and go to DONE.
REQ-030 In PSW, psw_we SHALL be 1 for exactly 1 cycle and psw_out = captured psw_in with bit 0 replaced as follows.
REQ-031 Bit 0 (parity P) SHALL be the XOR of the 8 bits of the new A: ans for mode 10, or for mode 01 with dest_addr=0xE0; for all other cases bit 0 SHALL keep psw_in[0].
REQ-032 DONE SHALL last 1 cycle with wb_done=1 and then return to IDLE; the best-case latency from acceptance to wb_done is 2 cycles (mode 01, immediate ack, no PSW).
REQ-033 In every state other than WR0/WR1, mem_we SHALL be 0; in every state other than PSW, psw_we SHALL be 0.
REQ-034 mem_ack received while mem_we=0 SHALL be ignored.

Reset
REQ-035 When rst_n=0 at a clk edge, the state SHALL become IDLE and the stall counter and all captured registers SHALL be 0.
REQ-036 While in reset, the outputs SHALL be: mem_we=0, mem_addr=0x00, mem_wdata=0x00, psw_we=0, psw_out=0x00, wb_done=0, wb_err=0, and wb_ready=0.
REQ-037 wb_ready SHALL be 1 from the first cycle after rst_n returns to 1.
REQ-038 Reset during WR0, WR1 or PSW SHALL abandon the operation with no further strobes and no wb_done.

Verification
REQ-039 Byte write: mode 01, dest_addr=0x30, ans=0x5A, psw_wr=0, mem_ack tied 1 -> one cycle with mem_we and 0x30/0x5A, wb_done 2 cycles after acceptance, psw_we never 1.
REQ-040 MUL pair: mode 10, ans=0x10, ans_hi=0x27, psw_in=0x84, psw_wr=1 -> writes 0xE0/0x10 then 0xF0/0x27, then psw_we with psw_out=0x85, then wb_done.
REQ-041 Stall: mode 01, mem_ack low for 3 cycles then high -> mem_we held 4 cycles with address/data constant, no wb_err, then wb_done.
REQ-042 Timeout: mode 10, mem_ack held 0 -> wb_err after 15 stall cycles, no WR1 write, no psw_we, then wb_done.
REQ-043 Reset mid-op: rst_n=0 during WR1 -> next cycle all outputs are 0, and wb_ready=1 the cycle after rst_n=1.
REQ-044 PSW only: mode 00, psw_wr=1, psw_in=0xC1 -> psw_we for 1 cycle with psw_out=0xC1, no mem_we, then wb_done.
